max11642_emu: RTL and testbench

MAX11642_EMU -- requirements
Module: max11642_emu

---
 rtl/max11642_pkg.sv | 27 ++
 rtl/spi_slave_byte.sv | 96 +++++++++
 rtl/max11642_emu.sv | 121 ++++++++++++
 tb/tb_max11642_emu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/max11642_pkg.sv
// Shared command encodings and controller states for the MAX11642 emulator
// and the controller that talks to it.
package max11642_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_CMD  = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam int unsigned CONV_BIT = 7;
  localparam int unsigned CHSEL_HI = 6;
  localparam int unsigned CHSEL_LO = 3;
  localparam int unsigned SCAN_HI  = 2;
  localparam int unsigned SCAN_LO  = 1;

  localparam logic [1:0] NO_SCAN   = 2'b11;
  localparam logic [1:0] SETUP_PFX = 2'b01;
  localparam logic [2:0] AVG_PFX   = 3'b001;
  localparam logic [3:0] RESET_PFX = 4'b0001;
  localparam logic [7:0] NOP_CMD   = 8'h00;

  function automatic logic [15:0] conv_word(input logic [7:0] sample);
    return {4'b0000, sample, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI slave front end: input synchronizers, SCLK/CS edge detection,
// MSB-first byte receiver and 16-bit MISO shift register.
module spi_slave_byte #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  input  logic        tx_load,
  input  logic        tx_en,
  input  logic [15:0] tx_word,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        cs_fall,
  output logic        cs_rise,
  output logic        miso
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [15:0]            tx_shift;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync[0] <= sclk;
      mosi_sync[0] <= mosi;
      cs_sync[0]   <= cs;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
      end
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!enable || cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // MISO changes on falling SCLK so the master sees a stable bit on the next rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      miso     <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= tx_word;
      miso     <= 1'b0;
    end else if (!enable || !tx_en || cs_s) begin
      miso <= 1'b0;
    end else if (sclk_fall) begin
      miso     <= tx_shift[15];
      tx_shift <= {tx_shift[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/max11642_emu.sv
// Behavioural MAX11642 ADC emulator: decodes SPI command bytes and returns
// a 16-bit conversion word built from the externally supplied channel samples.
module max11642_emu
  import max11642_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned POWER_UP_CYCLES = 7000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_SPI_Clk,
  input  logic         i_SPI_MOSI,
  input  logic         i_CS,
  output logic         o_SPI_MISO,
  input  logic [127:0] i_chan_data,
  output logic         o_ready,
  output logic         o_conv_valid,
  output logic [3:0]   o_conv_chnl,
  output logic [7:0]   o_setup_reg,
  output logic [7:0]   o_avg_reg,
  output logic         o_cmd_err
);

  state_t      state;
  logic [31:0] pwr_cnt;
  logic        rd_byte;
  logic        tx_load;
  logic [15:0] tx_word;
  logic [7:0]  rx_byte;
  logic        rx_valid, cs_fall, cs_rise;
  logic [3:0]  chsel;

  assign chsel = rx_byte[CHSEL_HI:CHSEL_LO];

  spi_slave_byte #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_spi (
    .clk     (i_clk),
    .rst     (i_rst),
    .enable  (o_ready),
    .sclk    (i_SPI_Clk),
    .mosi    (i_SPI_MOSI),
    .cs      (i_CS),
    .tx_load (tx_load),
    .tx_en   (state == READOUT),
    .tx_word (tx_word),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .cs_fall (cs_fall),
    .cs_rise (cs_rise),
    .miso    (o_SPI_MISO)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      pwr_cnt      <= '0;
      o_ready      <= 1'b0;
      o_conv_valid <= 1'b0;
      o_conv_chnl  <= '0;
      o_setup_reg  <= '0;
      o_avg_reg    <= '0;
      o_cmd_err    <= 1'b0;
      rd_byte      <= 1'b0;
      tx_load      <= 1'b0;
      tx_word      <= '0;
    end else begin
      o_conv_valid <= 1'b0;
      tx_load      <= 1'b0;
      if (!o_ready) begin
        if (pwr_cnt == 32'(POWER_UP_CYCLES - 1)) o_ready <= 1'b1;
        else pwr_cnt <= pwr_cnt + 32'd1;
      end

      if (!o_ready || cs_rise) begin
        state   <= IDLE;
        rd_byte <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) state <= RX_CMD;
          RX_CMD: begin
            if (rx_valid) begin
              if (rx_byte[CONV_BIT]) begin
                if (rx_byte[SCAN_HI:SCAN_LO] == NO_SCAN) begin
                  tx_word      <= conv_word(i_chan_data[{chsel, 3'b000} +: 8]);
                  tx_load      <= 1'b1;
                  o_conv_chnl  <= chsel;
                  o_conv_valid <= 1'b1;
                  rd_byte      <= 1'b0;
                  state        <= READOUT;
                end else begin
                  o_cmd_err <= 1'b1;
                end
              end else if (rx_byte[7:6] == SETUP_PFX) begin
                o_setup_reg <= rx_byte;
              end else if (rx_byte[7:5] == AVG_PFX) begin
                o_avg_reg <= rx_byte;
              end else if (rx_byte[7:4] == RESET_PFX) begin
                o_setup_reg <= '0;
                o_avg_reg   <= '0;
              end
            end
          end
          // Readout spans exactly two received byte slots; those bytes are swallowed.
          READOUT: begin
            if (rx_valid) begin
              if (rd_byte) begin
                rd_byte <= 1'b0;
                state   <= RX_CMD;
              end else begin
                rd_byte <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_max11642_emu.sv
// Directed bench for max11642_emu: power-up, register writes, conversions,
// bad SCAN handling and mid-readout abort.
module tb_max11642_emu;

  localparam int unsigned H = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         cs = 1'b1;
  logic [127:0] chan_data = '0;
  logic         miso, ready, conv_valid, cmd_err;
  logic [3:0]   conv_chnl;
  logic [7:0]   setup_reg, avg_reg;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  max11642_emu #(
    .SYNC_STAGES(2),
    .POWER_UP_CYCLES(20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_SPI_Clk   (sclk),
    .i_SPI_MOSI  (mosi),
    .i_CS        (cs),
    .o_SPI_MISO  (miso),
    .i_chan_data (chan_data),
    .o_ready     (ready),
    .o_conv_valid(conv_valid),
    .o_conv_chnl (conv_chnl),
    .o_setup_reg (setup_reg),
    .o_avg_reg   (avg_reg),
    .o_cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && conv_valid) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    wait_clk(H);
    r = miso;
    sclk = 1'b1;
    wait_clk(H);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(3 * H);
  endtask

  initial begin
    logic [7:0] rb, r1, r2;
    logic       b;
    int         p0;
    int         chans[10] = '{0, 1, 2, 3, 8, 9, 10, 11, 13, 14};

    wait_clk(3);
    check("rst_ready", ready, 0);
    check("rst_miso", miso, 0);
    check("rst_setup", setup_reg, 0);
    check("rst_avg", avg_reg, 0);
    check("rst_err", cmd_err, 0);
    check("rst_chnl", conv_chnl, 0);
    rst = 1'b0;

    fork
      begin
        for (int k = 1; k <= 20; k++) begin
          @(posedge clk);
          #1;
          if (k == 19) check("ready_c19", ready, 0);
          if (k == 20) check("ready_c20", ready, 1);
        end
      end
      begin
        wait_clk(10);
        cs_low();
        spi_byte(8'h55, rb);
        cs_high();
      end
    join
    check("early_byte_ignored", setup_reg, 8'h00);

    cs_low();
    spi_byte(8'h78, rb);
    check("setup_miso_bits", rb, 0);
    cs_high();
    check("setup_reg", setup_reg, 8'h78);
    check("setup_miso_idle", miso, 0);

    cs_low();
    spi_byte(8'h3A, rb);
    check("avg_reg", avg_reg, 8'h3A);
    spi_byte(8'h10, rb);
    check("rstreg_setup", setup_reg, 8'h00);
    check("rstreg_avg", avg_reg, 8'h00);
    cs_high();

    chan_data[13*8 +: 8] = 8'hA5;
    p0 = pulses;
    cs_low();
    spi_byte(8'hEE, rb);
    spi_byte(8'hEE, r1);
    spi_byte(8'hEE, r2);
    check("conv13_word", {r1, r2}, 16'h0A50);
    cs_high();
    check("conv13_pulses", pulses - p0, 1);
    check("conv13_chnl", conv_chnl, 4'd13);
    check("conv13_err", cmd_err, 0);

    for (int i = 0; i < 16; i++) chan_data[i*8 +: 8] = 8'(i + 16);
    p0 = pulses;
    cs_low();
    foreach (chans[j]) begin
      spi_byte({1'b1, 4'(chans[j]), 3'b110}, rb);
      spi_byte(8'h00, r1);
      spi_byte(8'h00, r2);
      check($sformatf("b2b_ch%0d", chans[j]), {r1, r2}, {4'h0, 8'(chans[j] + 16), 4'h0});
    end
    cs_high();
    check("b2b_pulses", pulses - p0, 10);
    check("b2b_last_chnl", conv_chnl, 4'd14);

    p0 = pulses;
    cs_low();
    spi_byte(8'h80, rb);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    check("badscan_err", cmd_err, 1);
    check("badscan_miso", {r1, r2}, 0);
    check("badscan_pulses", pulses - p0, 0);
    cs_high();

    chan_data[7:0] = 8'hFF;
    cs_low();
    spi_byte(8'h86, rb);
    for (int i = 0; i < 5; i++) spi_bit(1'b0, b);
    cs_high();
    check("abort_miso", miso, 0);
    chan_data[7:0] = 8'h3C;
    cs_low();
    spi_byte(8'h86, rb);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    check("after_abort_word", {r1, r2}, 16'h03C0);
    cs_high();
    check("after_abort_chnl", conv_chnl, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
